fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined successor of the single-cycle RV32I core.
- Owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid interface with variable latency (>=1 cycle).
- Buffers returned instructions with their PCs in a prefetch FIFO and hands them to decode through a valid/ready handshake.
- Supports redirect (branch/jump/trap) with a full flush, including discard of in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_sync_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   INSTR_W          - instruction word width
//   RESET_PC_DEFAULT - default fetch PC after reset
//   NOP_INSTR        - canonical NOP (addi x0,x0,0), used downstream for bubble insertion
package fetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with registered storage and flush.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   flush          - empty the FIFO (wins over push/pop)
//   push, wdata    - write request and data; ignored when full unless popping
//   pop            - read request; ignored when empty
//   rdata          - head entry (no bypass from wdata)
//   full, empty    - status
//   count          - number of stored entries
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues requests over a req/gnt/rvalid
// instruction-memory interface, buffers {pc, instr} in a prefetch FIFO and hands them to
// decode via valid/ready. A redirect flushes everything and discards in-flight responses.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   imem_req/addr/gnt            - request channel (addr = fpc[IMEM_AW-1:0])
//   imem_rvalid/rdata            - in-order response channel
//   redirect_vld/pc              - flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   if_valid/ready/instr/pc/pc4  - decode handshake and head entry
//   fetch_busy                   - requests outstanding or responses still to discard
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     IMEM_AW    = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_vld,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]    if_pc,
    output logic [XLEN-1:0]    if_pc4,
    output logic               fetch_busy
);

    localparam int unsigned CW = cnt_width(FIFO_DEPTH);
    localparam int unsigned OW = CW + 2;

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [CW-1:0]   osd_q, osd_d, drop_q, drop_d;
    logic            run_q;

    logic            grant, rsp_drop, rsp_take;
    logic [OW-1:0]   occ;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [XLEN+INSTR_W-1:0] fifo_rdata;

    logic            tag_full, tag_empty;
    logic [CW-1:0]   tag_count;
    logic [XLEN-1:0] tag_head;

    // Credits use current-cycle values only; a same-cycle pop does not free one.
    assign occ       = OW'(osd_q) + OW'(fifo_count) + OW'(drop_q);
    assign imem_req  = run_q && !redirect_vld && (occ < OW'(FIFO_DEPTH));
    assign imem_addr = fpc_q[IMEM_AW-1:0];
    assign grant     = imem_req && imem_gnt;

    // Responses owed to a pre-redirect request are discarded first; stray ones are ignored.
    assign rsp_drop  = imem_rvalid && (drop_q != '0);
    assign rsp_take  = imem_rvalid && (drop_q == '0) && !tag_empty;
    assign fifo_push = rsp_take && !redirect_vld;
    assign fifo_pop  = if_valid && if_ready && !redirect_vld;

    assign if_valid   = !fifo_empty;
    assign if_instr   = fifo_rdata[INSTR_W-1:0];
    assign if_pc      = fifo_rdata[INSTR_W +: XLEN];
    assign if_pc4     = fifo_empty ? '0 : if_pc + XLEN'(4);
    assign fetch_busy = (osd_q != '0) || (drop_q != '0);

    always_comb begin
        fpc_d  = fpc_q;
        osd_d  = osd_q;
        drop_d = drop_q;
        if (redirect_vld) begin
            fpc_d  = {redirect_pc[XLEN-1:2], 2'b00};
            osd_d  = '0;
            // Every outstanding response becomes a discard, less one arriving right now.
            drop_d = drop_q + osd_q - CW'(rsp_drop || rsp_take);
        end else begin
            if (grant) begin
                fpc_d = fpc_q + XLEN'(4);
            end
            osd_d  = osd_q + CW'(grant) - CW'(rsp_take);
            drop_d = drop_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q  <= {RESET_PC[XLEN-1:2], 2'b00};
            osd_q  <= '0;
            drop_q <= '0;
            run_q  <= 1'b0;
        end else begin
            fpc_q  <= fpc_d;
            osd_q  <= osd_d;
            drop_q <= drop_d;
            run_q  <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN + INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_vld),
        .push  (fifo_push),
        .wdata ({tag_head, imem_rdata}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // PC of each granted request, consumed in order as its response is accepted.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_vld),
        .push  (grant),
        .wdata (fpc_q),
        .pop   (fifo_push),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && osd_q == '0 && drop_q == '0));
    a_fifo_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));
    a_tag_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(grant && tag_full));
    a_tag_tracks_osd : assert property (@(posedge clk) disable iff (!rst_n)
        tag_count == osd_q);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [12:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        fetch_busy;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4),
        .IMEM_AW    (13)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc4       (if_pc4),
        .fetch_busy   (fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] addr;
        int          due;
    } mem_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_t        mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] dlv_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          ngrant = 0;
    logic        gnt_c, rdy_c, redir_c;
    logic [31:0] rpc_c, mpc, hold_addr;

    function automatic logic [31:0] mem_word(input logic [12:0] a);
        return {3'b101, a, 3'b011, ~a};
    endfunction

    function automatic logic [31:0] dlv_at(input int i);
        if (i < dlv_q.size()) return dlv_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory response and controls, then model grants and outputs.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
            mem_q.delete(0);
        end
        imem_gnt     = gnt_c;
        if_ready     = rdy_c;
        redirect_vld = redir_c;
        redirect_pc  = rpc_c;
        #1;
        if (redir_c) begin
            chk("req_in_redirect", 32'(imem_req), 32'd0);
            exp_q.delete();
            dlv_q.delete();
            mpc = {rpc_c[31:2], 2'b00};
        end else begin
            if (imem_req && imem_gnt) begin
                chk("imem_addr", 32'(imem_addr), 32'(mpc[12:0]));
                mem_q.push_back('{addr: imem_addr, due: cyc + lat});
                exp_q.push_back('{pc: mpc, instr: mem_word(mpc[12:0])});
                mpc = mpc + 32'd4;
                ngrant++;
            end
            if (if_valid && if_ready) begin
                chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", if_instr, e.instr);
                    chk("if_pc4", if_pc4, e.pc + 32'd4);
                end
                dlv_q.push_back(if_pc);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        redirect_vld = 1'b0;
        redirect_pc  = '0;
        if_ready     = 1'b0;
        redir_c      = 1'b0;
        ngrant       = 0;
        mem_q.delete();
        exp_q.delete();
        dlv_q.delete();
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc4, 32'd0);
        // Garbage response while reset is held must be ignored.
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_gnt    = gnt_c;
        if_ready    = rdy_c;
        rst_n       = 1'b1;
        mpc         = 32'h0;
        cyc         = 0;
        #1;
        chk("c0_req", 32'(imem_req), 32'd0);
        chk("c0_valid", 32'(if_valid), 32'd0);
        chk("c0_busy", 32'(fetch_busy), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        gnt_c   = 1'b1;
        rdy_c   = 1'b1;
        redir_c = 1'b0;
        rpc_c   = '0;
        lat     = 1;

        // Streaming with 1-cycle memory: first output in cycle 3, one per cycle after.
        do_reset();
        step();
        chk("t1_req_c1", 32'(imem_req), 32'd1);
        chk("t1_valid_c1", 32'(if_valid), 32'd0);
        step();
        chk("t1_valid_c2", 32'(if_valid), 32'd0);
        step();
        chk("t1_valid_c3", 32'(if_valid), 32'd1);
        chk("t1_pc_c3", if_pc, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_req", 32'(imem_req), 32'd1);
            chk("t1_valid", 32'(if_valid), 32'd1);
        end
        chk("t1_ndeliv", 32'(dlv_q.size()), 32'd11);
        chk("t1_last_pc", dlv_at(10), 32'h28);

        // Redirect coinciding with an rvalid and a pop.
        redir_c = 1'b1;
        rpc_c   = 32'h200;
        step();
        chk("t4_valid_at_redir", 32'(if_valid), 32'd1);
        redir_c = 1'b0;
        step();
        chk("t4_valid_after", 32'(if_valid), 32'd0);
        chk("t4_busy_after", 32'(fetch_busy), 32'd0);
        chk("t4_req_after", 32'(imem_req), 32'd1);
        chk("t4_addr_after", 32'(imem_addr), 32'h200);
        repeat (3) step();
        chk("t4_first_pc", dlv_at(0), 32'h200);

        // Grant withheld: address stable, FIFO drains and stays idle.
        gnt_c = 1'b0;
        repeat (3) step();
        hold_addr = 32'(imem_addr);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_addr_stable", 32'(imem_addr), hold_addr);
            chk("t5_req", 32'(imem_req), 32'd1);
            chk("t5_valid", 32'(if_valid), 32'd0);
            chk("t5_busy", 32'(fetch_busy), 32'd0);
        end
        gnt_c = 1'b1;
        ngrant = 0;
        repeat (6) step();
        chk("t5_resumed", 32'(ngrant), 32'd6);

        // Decode stalled: exactly FIFO_DEPTH grants, then drained in order.
        rdy_c = 1'b0;
        do_reset();
        repeat (8) step();
        chk("t2_ngrant", 32'(ngrant), 32'd4);
        chk("t2_req", 32'(imem_req), 32'd0);
        chk("t2_valid", 32'(if_valid), 32'd1);
        chk("t2_busy", 32'(fetch_busy), 32'd0);
        chk("t2_head", if_pc, 32'h0);
        rdy_c = 1'b1;
        repeat (6) step();
        chk("t2_d0", dlv_at(0), 32'h0);
        chk("t2_d1", dlv_at(1), 32'h4);
        chk("t2_d2", dlv_at(2), 32'h8);
        chk("t2_d3", dlv_at(3), 32'hC);

        // Redirect with two requests in flight (3-cycle memory): both discarded.
        lat = 3;
        do_reset();
        step();
        step();
        chk("t3_ngrant", 32'(ngrant), 32'd2);
        redir_c = 1'b1;
        rpc_c   = 32'h103;
        step();
        redir_c = 1'b0;
        step();
        chk("t3_busy_c4", 32'(fetch_busy), 32'd1);
        step();
        chk("t3_busy_c5", 32'(fetch_busy), 32'd1);
        repeat (6) step();
        chk("t3_first_pc", dlv_at(0), 32'h100);
        chk("t3_second_pc", dlv_at(1), 32'h104);

        // PC wrap at the top of the address space.
        lat = 1;
        do_reset();
        repeat (4) step();
        redir_c = 1'b1;
        rpc_c   = 32'hFFFF_FFFE;
        step();
        redir_c = 1'b0;
        repeat (6) step();
        chk("t6_first_pc", dlv_at(0), 32'hFFFF_FFFC);
        chk("t6_wrap_pc", dlv_at(1), 32'h0000_0000);
        chk("t6_third_pc", dlv_at(2), 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
